// File: rtl/gru_pkg.sv
// rtl/gru_pkg.sv - shared fixed-point constants and state encoding for GRU stages
package gru_pkg;
    localparam int DW      = 16;
    localparam int FRAC    = 12;
    localparam int SAT_MAX = (1 << (DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DW - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;
endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - round-half-up, bias add and saturate an accumulator to DW bits
module fxp_round_sat
    import gru_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [DW-1:0]    bias_i,
    output logic signed [DW-1:0]    y_o
);
    // One guard bit so adding the rounding constant cannot wrap near full scale.
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W:0] HI  = (ACC_W + 1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] LO  = (ACC_W + 1)'(SAT_MIN);

    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] biased;

    always_comb begin
        acc_x   = {acc_i[ACC_W-1], acc_i};
        rounded = (acc_x + RND) >>> FRAC;
        biased  = rounded + (ACC_W + 1)'(bias_i);
        if (biased > HI) begin
            y_o = DW'(SAT_MAX);
        end else if (biased < LO) begin
            y_o = DW'(SAT_MIN);
        end else begin
            y_o = biased[DW-1:0];
        end
    end
endmodule

// File: rtl/gru_l1_mac.sv
// rtl/gru_l1_mac.sv - layer-1 windowed dot-product sequencer with rounded, biased, saturated output
module gru_l1_mac
    import gru_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int AW    = 10,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          idx_in,
    input  logic                 idx_stb,
    output logic [AW-1:0]        x_addr,
    input  logic signed [DW-1:0] x_rdata,
    output logic [AW-1:0]        w_addr,
    input  logic signed [DW-1:0] w_rdata,
    input  logic signed [DW-1:0] bias,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int TW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_e                   state_q, state_d;
    logic [TW-1:0]            tap_q, tap_d;
    logic [AW-1:0]            base_q, base_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]     y_q;
    logic                     y_valid_q;
    logic                     overrun_q;

    logic                     accept;
    logic                     acc_en;
    logic                     last_tap;
    logic signed [2*DW-1:0]   prod;
    logic signed [DW-1:0]     y_next;
    logic                     unused_idx;

    assign unused_idx = ^idx_in[31:AW];
    assign last_tap   = (tap_q == TW'(N_IN - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (idx_stb) state_d = ST_ISSUE;
            ST_ISSUE: if (last_tap) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   state_d = idx_stb ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Products trail their addresses by one cycle, so tap 0 accumulates on the second ISSUE cycle.
    always_comb begin
        accept = idx_stb && (state_q == ST_IDLE || state_q == ST_OUT);
        busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        acc_en = (state_q == ST_ISSUE && tap_q != '0) || (state_q == ST_DRAIN);
        x_addr = '0;
        w_addr = '0;
        if (state_q == ST_ISSUE) begin
            x_addr = base_q + AW'(tap_q);
            w_addr = AW'(tap_q);
        end
    end

    always_comb begin
        prod   = x_rdata * w_rdata;
        acc_d  = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        tap_d  = (state_q == ST_ISSUE && !last_tap) ? tap_q + TW'(1) : '0;
        base_d = accept ? idx_in[AW-1:0] : base_q;
    end

    fxp_round_sat #(.ACC_W(ACC_W)) u_round_sat (
        .acc_i  (acc_d),
        .bias_i (bias),
        .y_o    (y_next)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tap_q     <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tap_q     <= tap_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            y_valid_q <= (state_q == ST_DRAIN);
            overrun_q <= overrun_q | (idx_stb & busy);
            if (state_q == ST_DRAIN) begin
                y_q <= y_next;
            end
        end
    end

    assign y_out   = y_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_gru_l1_mac.sv
// tb/tb_gru_l1_mac.sv - scoreboard bench for gru_l1_mac with directed windows
module tb_gru_l1_mac;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [31:0]        idx_in = '0;
    logic               idx_stb = 1'b0;
    logic [9:0]         x_addr, w_addr;
    logic signed [15:0] x_rdata = '0, w_rdata = '0, bias = '0;
    logic signed [15:0] y_out;
    logic               y_valid, busy, overrun;

    logic signed [15:0] x_mem [1024];
    logic signed [15:0] w_mem [1024];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct { int cyc; logic signed [15:0] y; } yexp_t;
    typedef struct { int cyc; logic [9:0] xa; logic [9:0] wa; } aexp_t;
    yexp_t yq[$];
    aexp_t aq[$];
    yexp_t ye;
    aexp_t ae;

    gru_l1_mac dut (
        .clk     (clk),
        .rstn    (rstn),
        .idx_in  (idx_in),
        .idx_stb (idx_stb),
        .x_addr  (x_addr),
        .x_rdata (x_rdata),
        .w_addr  (w_addr),
        .w_rdata (w_rdata),
        .bias    (bias),
        .y_out   (y_out),
        .y_valid (y_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        x_rdata <= x_mem[x_addr];
        w_rdata <= w_mem[w_addr];
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (y_valid) begin
            if (yq.size() == 0) begin
                check("unexpected_y_valid", 1, 0);
            end else begin
                ye = yq.pop_front();
                check("y_valid_cycle", cyc, ye.cyc);
                check("y_out", y_out, ye.y);
            end
        end
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            ae = aq.pop_front();
            check("x_addr", x_addr, ae.xa);
            check("w_addr", w_addr, ae.wa);
        end
        if (cyc > 3000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 3000", cyc);
            $fatal(1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle strobe in the current cycle; optionally queue the window's expectations.
    task automatic strobe(input logic [31:0] idx, input int y_exp, input bit expect_y);
        int s;
        yexp_t y;
        aexp_t a;
        s = cyc;
        idx_in  = idx;
        idx_stb = 1'b1;
        if (expect_y) begin
            y.cyc = s + 10;
            y.y   = 16'(y_exp);
            yq.push_back(y);
            for (int k = 0; k < 8; k++) begin
                a.cyc = s + 1 + k;
                a.xa  = 10'((idx + 32'(k)) & 32'h3FF);
                a.wa  = 10'(k);
                aq.push_back(a);
            end
        end
        idle(1);
        idx_stb = 1'b0;
    endtask

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < 1024; i++) begin
            x_mem[i] = 16'(xv);
            w_mem[i] = 16'(wv);
        end
    endtask

    initial begin
        fill(4096, 512);
        idle(3);
        rstn = 1'b1;
        check("rst_y_out", y_out, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_x_addr", x_addr, 0);
        check("rst_w_addr", w_addr, 0);

        strobe(5, 4096, 1);
        check("busy_first_issue", busy, 1);
        idle(8);
        check("busy_drain", busy, 1);
        idle(1);
        check("busy_out", busy, 0);
        idle(3);

        fill(4096, 4096);
        strobe(5, 32767, 1);
        idle(13);

        fill(-4096, 8192);
        strobe(0, -32768, 1);
        idle(13);

        fill(0, 2048);
        x_mem[20] = 16'sd1;
        bias = 16'sd3;
        strobe(20, 4, 1);
        idle(13);
        bias = '0;

        fill(0, 4096);
        for (int i = 0; i < 1024; i++) x_mem[i] = 16'(i);
        strobe(32'h8000_03FC, 4092, 1);
        idle(13);

        for (int i = 1; i <= 5; i++) begin
            strobe(32'(100 * i), 800 * i + 28, 1);
            idle(9);
        end
        idle(5);
        check("overrun_back_to_back", overrun, 0);

        strobe(40, 348, 1);
        idle(2);
        strobe(300, 0, 0);
        check("overrun_set", overrun, 1);
        idle(13);

        strobe(60, 0, 0);
        idle(4);
        rstn = 1'b0;
        idle(1);
        check("abort_busy", busy, 0);
        check("abort_y_valid", y_valid, 0);
        check("abort_overrun", overrun, 0);
        check("abort_x_addr", x_addr, 0);
        rstn = 1'b1;
        idle(14);

        strobe(7, 84, 1);
        idle(13);

        check("y_queue_empty", yq.size(), 0);
        check("addr_queue_empty", aq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
